// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial accelerator: register offsets,
// FSM state encoding, STATUS bit positions and datapath widths.
package factorial_pkg;

    localparam int MUL_BITS_DFLT = 64;
    localparam int RESULT_W      = 128;

    // Register offsets, decoded from s_addr[5:3]
    localparam logic [2:0] OFS_OPSTART  = 3'd0;
    localparam logic [2:0] OFS_OPCLEAR  = 3'd1;
    localparam logic [2:0] OFS_STATUS   = 3'd2;
    localparam logic [2:0] OFS_INTR_EN  = 3'd3;
    localparam logic [2:0] OFS_OPERAND  = 3'd4;
    localparam logic [2:0] OFS_RESULT_H = 3'd5;
    localparam logic [2:0] OFS_RESULT_L = 3'd6;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/factorial_core_mult_seq.sv
// mult_seq: sequential shift-add multiplier, 128-bit a times MUL_BITS-bit b,
// product truncated to 128 bits.
//   clk, reset_n : clock and synchronous active-low reset
//   clear        : abort any multiply in progress and clear the result
//   start        : load a/b; iterations run on the following MUL_BITS edges
//   a, b         : operands, sampled on the start edge
//   product      : accumulated product, final once done is high
//   done         : high from the last iteration edge until the next start/clear
module mult_seq
    import factorial_pkg::*;
#(
    parameter int MUL_BITS = MUL_BITS_DFLT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                start,
    input  logic [RESULT_W-1:0] a,
    input  logic [MUL_BITS-1:0] b,
    output logic [RESULT_W-1:0] product,
    output logic                done
);

    localparam int ITER_W = $clog2(MUL_BITS + 1);

    logic [RESULT_W-1:0] a_q;
    logic [RESULT_W-1:0] acc_q;
    logic [MUL_BITS-1:0] b_q;
    logic [ITER_W-1:0]   iter_q;
    logic                done_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            a_q    <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            iter_q <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            acc_q  <= '0;
            b_q    <= b;
            iter_q <= ITER_W'(MUL_BITS);
            done_q <= 1'b0;
        end else if (iter_q != '0) begin
            // One multiplier bit per edge, LSB first; bits shifted past
            // bit 127 of a_q are the intended truncation.
            if (b_q[0]) begin
                acc_q <= acc_q + a_q;
            end
            a_q    <= a_q << 1;
            b_q    <= b_q >> 1;
            iter_q <= iter_q - ITER_W'(1);
            done_q <= (iter_q == ITER_W'(1));
        end
    end

    assign product = acc_q;
    assign done    = done_q;

endmodule

// File: rtl/factorial_core.sv
// factorial_core: bus slave computing N! (128-bit truncated) for a 64-bit
// operand by repeated calls to the mult_seq shift-add multiplier.
//   clk, reset_n : clock and synchronous active-low reset
//   s_sel, s_wr  : slave select and write strobe from the bus
//   s_addr       : byte address, register offset in s_addr[5:3]
//   s_din        : write data
//   s_dout       : registered read data, valid the cycle after the read
//   interrupt    : registered intr_en & done
//
// state   | meaning
// IDLE    | waiting for OPSTART
// MUL     | multiply in flight; busy=1
// DONE    | result valid; done=1 until OPCLEAR or reset
module factorial_core
    import factorial_pkg::*;
#(
    parameter int MUL_BITS = MUL_BITS_DFLT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        interrupt
);

    state_e              state_q;
    logic [63:0]         operand_q;
    logic [63:0]         cnt_q;
    logic [RESULT_W-1:0] result_q;
    logic                intr_en_q;
    logic                interrupt_q;
    logic [63:0]         s_dout_q;

    logic [2:0]          ofs;
    logic                wr_en;
    logic                rd_en;
    logic                opstart;
    logic                opclear;
    logic                intr_wr;
    logic                busy;
    logic                done;
    logic [63:0]         cnt_m1;
    logic [63:0]         rd_data;
    logic                interrupt_d;

    logic                mult_start;
    logic [RESULT_W-1:0] mult_a;
    logic [MUL_BITS-1:0] mult_b;
    logic [RESULT_W-1:0] mult_product;
    logic                mult_done;

    logic                unused_addr;

    assign ofs         = s_addr[5:3];
    assign unused_addr = ^{s_addr[15:6], s_addr[2:0]};
    assign wr_en       = s_sel & s_wr;
    assign rd_en       = s_sel & ~s_wr;
    assign opstart     = wr_en && (ofs == OFS_OPSTART) && s_din[0];
    assign opclear     = wr_en && (ofs == OFS_OPCLEAR) && s_din[0];
    assign intr_wr     = wr_en && (ofs == OFS_INTR_EN);
    assign busy        = (state_q == ST_MUL);
    assign done        = (state_q == ST_DONE);
    assign cnt_m1      = cnt_q - 64'd1;

    // Interrupt follows done & intr_en one cycle late, but drops on the
    // same edge that clears either of them.
    assign interrupt_d = done & intr_en_q & ~opclear & ~(intr_wr & ~s_din[0]);

    // Multiplier launch is combinational so a new multiply starts on the
    // very edge the FSM accepts the start or commits the previous product.
    always_comb begin
        mult_start = 1'b0;
        mult_a     = '0;
        mult_b     = '0;
        if (!opclear) begin
            if (state_q == ST_IDLE && opstart && operand_q >= 64'd2) begin
                mult_start = 1'b1;
                mult_a     = RESULT_W'(1);
                mult_b     = MUL_BITS'(operand_q);
            end else if (state_q == ST_MUL && mult_done && cnt_m1 >= 64'd2) begin
                mult_start = 1'b1;
                mult_a     = mult_product;
                mult_b     = MUL_BITS'(cnt_m1);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (ofs)
            OFS_STATUS: begin
                rd_data[STATUS_DONE_BIT] = done;
                rd_data[STATUS_BUSY_BIT] = busy;
            end
            OFS_INTR_EN:  rd_data[0] = intr_en_q;
            OFS_OPERAND:  rd_data    = operand_q;
            OFS_RESULT_H: rd_data    = result_q[127:64];
            OFS_RESULT_L: rd_data    = result_q[63:0];
            default:      rd_data    = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            operand_q   <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            intr_en_q   <= 1'b0;
            interrupt_q <= 1'b0;
            s_dout_q    <= '0;
        end else begin
            s_dout_q    <= rd_en ? rd_data : 64'd0;
            interrupt_q <= interrupt_d;

            if (intr_wr) begin
                intr_en_q <= s_din[0];
            end
            if (wr_en && ofs == OFS_OPERAND && !busy) begin
                operand_q <= s_din;
            end

            if (opclear) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                result_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (opstart) begin
                            result_q <= RESULT_W'(1);
                            cnt_q    <= operand_q;
                            state_q  <= (operand_q < 64'd2) ? ST_DONE : ST_MUL;
                        end
                    end
                    ST_MUL: begin
                        if (mult_done) begin
                            result_q <= mult_product;
                            cnt_q    <= cnt_m1;
                            if (cnt_m1 < 64'd2) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_dout    = s_dout_q;
    assign interrupt = interrupt_q;

    mult_seq #(
        .MUL_BITS (MUL_BITS)
    ) u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (opclear),
        .start   (mult_start),
        .a       (mult_a),
        .b       (mult_b),
        .product (mult_product),
        .done    (mult_done)
    );

endmodule

// File: tb/tb_factorial_core.sv
// Self-checking bench for factorial_core: directed sequence plus randomized
// operands, compared against a plain-arithmetic factorial reference.
module tb_factorial_core;

    localparam logic [2:0] A_OPSTART  = 3'd0;
    localparam logic [2:0] A_OPCLEAR  = 3'd1;
    localparam logic [2:0] A_STATUS   = 3'd2;
    localparam logic [2:0] A_INTR_EN  = 3'd3;
    localparam logic [2:0] A_OPERAND  = 3'd4;
    localparam logic [2:0] A_RESULT_H = 3'd5;
    localparam logic [2:0] A_RESULT_L = 3'd6;
    localparam int unsigned MUL_CYC   = 65;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout;
    logic        interrupt;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    factorial_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_sel     (s_sel),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .s_dout    (s_dout),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // N! truncated to 128 bits.
    function automatic logic [127:0] fact_ref(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (int k = 2; k <= int'(n); k++) r = r * 128'(k);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Random don't-care address bits around the offset field.
    task automatic set_addr(input logic [2:0] ofs);
        logic [15:0] r;
        r = 16'($urandom());
        s_addr = {r[15:6], ofs, r[2:0]};
    endtask

    task automatic bus_write(input logic [2:0] ofs, input logic [63:0] d);
        s_sel = 1'b1; s_wr = 1'b1; set_addr(ofs); s_din = d;
        @(posedge clk); #1;
        s_sel = 1'b0; s_wr = 1'b0; s_din = '0; s_addr = '0;
    endtask

    task automatic bus_read(input logic [2:0] ofs, output logic [63:0] d);
        s_sel = 1'b1; s_wr = 1'b0; set_addr(ofs);
        @(posedge clk); #1;
        d = s_dout;
        s_sel = 1'b0; s_addr = '0;
    endtask

    task automatic wait_edge(input int unsigned target);
        while (cyc < target - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic read_at(input logic [2:0] ofs, input int unsigned target, output logic [63:0] d);
        wait_edge(target);
        bus_read(ofs, d);
    endtask

    task automatic run_fact(input logic [63:0] n, input logic ie);
        logic [63:0]  d;
        logic [127:0] exp;
        int unsigned  s, dn;
        exp = fact_ref(n);
        bus_write(A_INTR_EN, {63'd0, ie});
        bus_write(A_OPERAND, n);
        bus_write(A_OPSTART, 64'd1);
        s  = cyc;
        dn = (n < 64'd2) ? s : s + MUL_CYC * (int'(n) - 1);
        if (n >= 64'd2) begin
            read_at(A_STATUS, s + 1, d);  check("status_busy_first", d, 64'h2);
            read_at(A_STATUS, dn, d);     check("status_busy_last", d, 64'h2);
            check("irq_before_done", interrupt, 0);
        end
        read_at(A_STATUS, dn + 1, d);     check("status_done", d, 64'h1);
        check("irq_after_done", interrupt, ie);
        bus_read(A_RESULT_L, d);          check("result_l", d, exp[63:0]);
        bus_read(A_RESULT_H, d);          check("result_h", d, exp[127:64]);
        bus_write(A_OPSTART, 64'd1);
        bus_read(A_STATUS, d);            check("opstart_in_done_status", d, 64'h1);
        bus_read(A_RESULT_L, d);          check("opstart_in_done_result", d, exp[63:0]);
        bus_write(A_OPCLEAR, 64'd1);
        check("irq_after_clear", interrupt, 0);
        bus_read(A_STATUS, d);            check("status_after_clear", d, 64'h0);
        bus_read(A_RESULT_L, d);          check("result_after_clear", d, 64'h0);
    endtask

    initial begin
        logic [63:0]  d;
        logic [127:0] exp;
        int unsigned  s;

        reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        check("reset_irq", interrupt, 0);
        check("reset_dout", s_dout, 64'h0);
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), d);
            check($sformatf("reset_read_ofs%0d", i), d, 64'h0);
        end

        run_fact(64'd5, 1'b1);
        run_fact(64'd21, 1'b0);
        run_fact(64'd0, 1'b1);
        run_fact(64'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_fact(64'($urandom_range(2, 40)), 1'($urandom_range(0, 1)));
        end
        run_fact(64'($urandom_range(35, 80)), 1'b1);

        // OPERAND write and OPSTART while busy are both ignored.
        bus_write(A_INTR_EN, 64'd1);
        bus_write(A_OPERAND, 64'd10);
        bus_write(A_OPSTART, 64'd1);
        s = cyc;
        wait_edge(s + 100);
        bus_write(A_OPERAND, 64'd3);
        bus_write(A_OPSTART, 64'd1);
        bus_read(A_OPERAND, d);                     check("operand_write_busy", d, 64'd10);
        read_at(A_STATUS, s + 9 * MUL_CYC + 1, d);  check("busy_ignore_done", d, 64'h1);
        exp = fact_ref(64'd10);

        // Registered read latency.
        @(posedge clk); #1;
        check("dout_idle", s_dout, 64'h0);
        s_sel = 1'b1; s_wr = 1'b0; set_addr(A_RESULT_L);
        #1;
        check("dout_before_edge", s_dout, 64'h0);
        @(posedge clk); #1;
        check("dout_after_edge", s_dout, exp[63:0]);
        s_sel = 1'b0;
        @(posedge clk); #1;
        check("dout_deselected", s_dout, 64'h0);

        // OPCLEAR mid-multiply aborts without committing anything.
        bus_write(A_OPCLEAR, 64'd1);
        bus_write(A_OPSTART, 64'd1);
        s = cyc;
        wait_edge(s + 50);
        bus_write(A_OPCLEAR, 64'd1);
        bus_read(A_STATUS, d);       check("abort_status", d, 64'h0);
        bus_read(A_RESULT_L, d);     check("abort_result_l", d, 64'h0);
        bus_read(A_RESULT_H, d);     check("abort_result_h", d, 64'h0);
        wait_edge(cyc + 700);
        bus_read(A_STATUS, d);       check("abort_status_late", d, 64'h0);
        check("abort_irq", interrupt, 0);

        // Synchronous reset mid-multiply.
        bus_write(A_OPERAND, 64'd10);
        bus_write(A_OPSTART, 64'd1);
        s = cyc;
        wait_edge(s + 30);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midreset_irq", interrupt, 0);
        check("midreset_dout", s_dout, 64'h0);
        bus_read(A_STATUS, d);       check("midreset_status", d, 64'h0);
        bus_read(A_OPERAND, d);      check("midreset_operand", d, 64'h0);
        bus_read(A_INTR_EN, d);      check("midreset_intr_en", d, 64'h0);
        bus_read(A_RESULT_L, d);     check("midreset_result_l", d, 64'h0);
        run_fact(64'd6, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
